// File: rtl/fc_weight_bank_stream.sv
// fc_weight_bank_stream: banked FC weight store behind one linear address space.
// A sequencer runs burst loads (valid/ready in) and burst streaming reads
// (valid/ready out through a 2-entry skid buffer with a 1-cycle SRAM bypass).
// Optional build macro FC_WMEM_WRAP_EN: read bursts wrap from TOTAL-1 to 0
// instead of being truncated (with err) at the end of the address space.

// Single-port bank: one access per cycle, registered read data.
module fc_wbank_sram #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          en,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    // Write when wr, otherwise read into the output register; idle bank holds
    always_ff @(posedge clk) begin
        if (en) begin
            if (wr) mem[addr] <= wdata;
            else    rdata_q   <= mem[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

module fc_weight_bank_stream #(
    parameter int                      LANES      = 32,
    parameter int                      BITSIZE    = 14,
    parameter int                      NUM_BANKS  = 2,
    parameter logic [NUM_BANKS*16-1:0] DEPTH_LIST = {16'd1256, 16'd32768},
    parameter int                      ADDR_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [ADDR_W-1:0]        load_base,
    input  logic                     load_valid,
    input  logic [LANES*BITSIZE-1:0] load_data,
    output logic                     load_ready,
    input  logic                     rd_start,
    input  logic [ADDR_W-1:0]        rd_base,
    input  logic [ADDR_W-1:0]        rd_len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*BITSIZE-1:0] out_data,
    output logic                     out_last,
    output logic [1:0]               out_bank,
    output logic                     busy,
    output logic                     err
);
    localparam int W = LANES * BITSIZE;

    // First global address of bank b (b == NUM_BANKS gives the total size)
    function automatic int bank_base(input int b);
        int s;
        s = 0;
        for (int i = 0; i < b; i++) s += int'(DEPTH_LIST[i*16 +: 16]);
        return s;
    endfunction

    localparam int                TOTAL  = bank_base(NUM_BANKS);
    localparam logic [ADDR_W:0]   TOTAL_X = (ADDR_W+1)'(TOTAL);
    localparam logic [ADDR_W:0]   LAST_X  = (ADDR_W+1)'(TOTAL - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN} state_e;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   bank;
        logic         last;
    } word_t;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    rem_q, rem_d;      // reads still to issue
    logic               err_q, err_d;
    logic               rd_vld_q, rd_vld_d;  // read in flight at SRAM output
    logic [1:0]         rd_bank_q, rd_bank_d;
    logic               rd_last_q, rd_last_d;
    logic [1:0]         fifo_cnt_q, fifo_cnt_d;
    word_t              ent0_q, ent0_d, ent1_q, ent1_d;

    logic [1:0]                  cur_bank;
    logic [ADDR_W-1:0]           next_addr;
    logic                        wr_fire, rd_issue;
    logic                        pop, push, space;
    logic [1:0]                  occ, occ_after, cnt_v;
    logic [W-1:0]                rd_mux;
    word_t                       sram_word, head;
    logic [NUM_BANKS-1:0][W-1:0] bank_rdata;

    // Bank decode on the registered global address; read-address successor wraps at TOTAL-1
    always_comb begin
        cur_bank = '0;
        for (int b = 1; b < NUM_BANKS; b++)
            if ({1'b0, addr_q} >= (ADDR_W+1)'(bank_base(b))) cur_bank = 2'(b);
        next_addr = ({1'b0, addr_q} == LAST_X) ? '0 : addr_q + ADDR_W'(1);
    end

    // Per-bank SRAM; only the decoded bank is enabled, the rest stay idle
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam int D    = int'(DEPTH_LIST[b*16 +: 16]);
        localparam int LAW  = (D > 1) ? $clog2(D) : 1;
        localparam int BASE = bank_base(b);
        logic [LAW-1:0] laddr;
        logic           en;
        assign laddr = LAW'(addr_q - ADDR_W'(BASE));
        assign en    = (cur_bank == 2'(b)) && (wr_fire || rd_issue);
        fc_wbank_sram #(.DEPTH(D), .W(W), .AW(LAW)) u_sram (
            .clk  (clk),
            .en   (en),
            .wr   (wr_fire),
            .addr (laddr),
            .wdata(load_data),
            .rdata(bank_rdata[b])
        );
    end

    // Select the bank that served the in-flight read
    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (rd_bank_q == 2'(b)) rd_mux = bank_rdata[b];
    end

    // Skid buffer: head is the oldest stored word, else the SRAM output bypassed.
    // A stalled SRAM word is captured so a later read can't overwrite it.
    always_comb begin
        sram_word  = '{data: rd_mux, bank: rd_bank_q, last: rd_last_q};
        head       = (fifo_cnt_q != 2'd0) ? ent0_q : sram_word;
        out_valid  = (fifo_cnt_q != 2'd0) || rd_vld_q;
        pop        = out_valid && out_ready;
        occ        = fifo_cnt_q + {1'b0, rd_vld_q};
        occ_after  = occ - {1'b0, pop};
        space      = occ_after < 2'd2;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        cnt_v      = fifo_cnt_q;
        if (pop && fifo_cnt_q != 2'd0) begin
            ent0_d = ent1_q;
            cnt_v  = cnt_v - 2'd1;
        end
        push = rd_vld_q && !(pop && fifo_cnt_q == 2'd0);
        if (push) begin
            if (cnt_v == 2'd0) ent0_d = sram_word;
            else               ent1_d = sram_word;
            cnt_v = cnt_v + 2'd1;
        end
        fifo_cnt_d = cnt_v;
    end

    // Sequencer next-state: start decode, load/read address walk, sticky err
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        err_d    = err_q;
        wr_fire  = 1'b0;
        rd_issue = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_start) begin
                    if ({1'b0, rd_base} >= TOTAL_X) begin
                        err_d = 1'b1;
                    end else if (rd_len != '0) begin
                        state_d = S_READ;
                        addr_d  = rd_base;
`ifdef FC_WMEM_WRAP_EN
                        rem_d = {1'b0, rd_len};
`else
                        if (({1'b0, rd_base} + {1'b0, rd_len}) > TOTAL_X) begin
                            rem_d = TOTAL_X - {1'b0, rd_base};
                            err_d = 1'b1;
                        end else begin
                            rem_d = {1'b0, rd_len};
                        end
`endif
                    end
                end else if (load_start) begin
                    if ({1'b0, load_base} >= TOTAL_X) err_d = 1'b1;
                    else begin
                        state_d = S_LOAD;
                        addr_d  = load_base;
                    end
                end
            end
            S_LOAD: begin
                if (rd_start) err_d = 1'b1;
                if (load_valid) begin
                    wr_fire = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    if ({1'b0, addr_q} == LAST_X) state_d = S_IDLE;
                end
                // load_start doubles as the stop pulse while loading
                if (load_start) state_d = S_IDLE;
            end
            S_READ: begin
                if (rd_start || load_start) err_d = 1'b1;
                if (space) begin
                    rd_issue = 1'b1;
                    addr_d   = next_addr;
                    rem_d    = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rd_start || load_start) err_d = 1'b1;
                if (occ_after == 2'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        rd_vld_d  = rd_issue;
        rd_bank_d = rd_issue ? cur_bank : rd_bank_q;
        rd_last_d = rd_issue && (rem_q == (ADDR_W+1)'(1));
    end

    // State, counters, read pipeline and skid buffer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_bank_q  <= '0;
            rd_last_q  <= 1'b0;
            fifo_cnt_q <= '0;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            rd_vld_q   <= rd_vld_d;
            rd_bank_q  <= rd_bank_d;
            rd_last_q  <= rd_last_d;
            fifo_cnt_q <= fifo_cnt_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
        end
    end

    assign load_ready = (state_q == S_LOAD);
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign out_data   = out_valid ? head.data : '0;
    assign out_bank   = out_valid ? head.bank : 2'b0;
    assign out_last   = out_valid && head.last;
endmodule

// File: tb/tb_fc_weight_bank_stream.sv
// Bench for fc_weight_bank_stream on a reduced map: bank0 64 words, bank1 40
// words (TOTAL 104), 4 lanes. A memory model plus an expected-word queue check
// every delivered word; read bursts come from a vector table.
module tb_fc_weight_bank_stream;
    localparam int LANES = 4, BITSIZE = 14, ADDR_W = 16;
    localparam int W = LANES * BITSIZE;
    localparam int D0 = 64, D1 = 40, TOTAL = D0 + D1;

    logic              clk = 0, rst = 0;
    logic              load_start = 0, load_valid = 0, load_ready;
    logic [ADDR_W-1:0] load_base = 0, rd_base = 0, rd_len = 0;
    logic [W-1:0]      load_data = 0, out_data;
    logic              rd_start = 0, out_valid, out_ready = 1, out_last, busy, err;
    logic [1:0]        out_bank;

    fc_weight_bank_stream #(.LANES(LANES), .BITSIZE(BITSIZE), .NUM_BANKS(2),
                            .DEPTH_LIST({16'd40, 16'd64}), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_bank(out_bank), .busy(busy), .err(err));

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] data; logic [1:0] bank; logic last; } exp_t;
    typedef struct { string nm; int base; int len; int mode; int inj; int n; bit err; } vec_t;

    exp_t         sb[$];
    logic [W-1:0] mem_model [TOTAL];
    int           n_tests = 0, n_fail = 0, delivered = 0;
    int           rdy_mode = 0;
    logic         rdy_ph = 0;
    logic         stall_q = 0, busy_chk = 0;
    logic [W-1:0] stall_data = '0;
    vec_t         tbl [10];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pattern(input int a, input int seed);
        logic [BITSIZE-1:0] v;
        v = BITSIZE'(a ^ seed);
        return {LANES{v}};
    endfunction

    // Consumer ready pattern: 0 always, 1 toggle 1010.., 2 random
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin rdy_ph = ~rdy_ph; out_ready = rdy_ph; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard compare, stall stability, busy drop after last
    always @(negedge clk) begin
        if (!rst) begin
            stall_q  = 0;
            busy_chk = 0;
        end else begin
            if (busy_chk) begin
                check("busy_after_last", {63'd0, busy}, 64'd0);
                busy_chk = 0;
            end
            if (stall_q) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_data", 64'(out_data), 64'(stall_data));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_word: got %0h expected no word", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word_data", 64'(out_data), 64'(e.data));
                    check("word_bank", 64'(out_bank), 64'(e.bank));
                    check("word_last", {63'd0, out_last}, {63'd0, e.last});
                    delivered++;
                    if (e.last) busy_chk = 1;
                end
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 0;
        @(negedge clk); rst = 1;
    endtask

    task automatic load_burst(input int base, input int n, input int seed, input bit stop);
        int gaps;
        gaps = 0;
        @(negedge clk); load_start = 1; load_base = 16'(base);
        @(negedge clk); load_start = 0;
        for (int i = 0; i < n; i++) begin
            load_valid = 1;
            load_data  = pattern(base + i, seed);
            load_start = stop && (i == n - 1);
            if (!load_ready) gaps++;
            mem_model[base + i] = load_data;
            @(negedge clk);
        end
        load_start = 0;
        if (stop) begin
            // a beat offered after the stop pulse must be refused
            load_data = pattern(base + n, 16'h1555);
            check("load_stop_ready", {63'd0, load_ready}, 64'd0);
            @(negedge clk);
        end
        load_valid = 0;
        check("load_ready_gaps", 64'(gaps), 64'd0);
        check("load_end_busy", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_burst(input vec_t v);
        int cyc, budget;
        rdy_ph = 0;
        rdy_mode = v.mode;
        for (int i = 0; i < v.n; i++) begin
            int a;
            a = (v.base + i) % TOTAL;
            sb.push_back('{data: mem_model[a], bank: 2'(a >= D0), last: (i == v.n - 1)});
        end
        delivered = 0;
        @(negedge clk); rd_start = 1; rd_base = 16'(v.base); rd_len = 16'(v.len);
        @(negedge clk); rd_start = 0;
        check({v.nm, "_lat1_valid"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check({v.nm, "_lat2_valid"}, {63'd0, out_valid}, 64'(v.n > 0));
        cyc = 0;
        budget = 4 * v.n + 40;
        while ((sb.size() != 0 || busy) && cyc < budget) begin
            if (cyc == v.inj) begin
                rd_start = 1; rd_base = 16'(v.base + 1); rd_len = 16'd3;
            end else rd_start = 0;
            @(negedge clk);
            cyc++;
        end
        rd_start = 0;
        rdy_mode = 0;
        if (cyc >= budget) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got %0d cycles required < %0d", v.nm, cyc, budget);
        end
        check({v.nm, "_err"}, {63'd0, err}, {63'd0, v.err});
        check({v.nm, "_count"}, 64'(delivered), 64'(v.n));
        check({v.nm, "_busy_end"}, {63'd0, busy}, 64'd0);
        sb.delete();
    endtask

    initial begin
        vec_t v;
        int   cyc;
        tbl[0] = '{"full",       0, TOTAL, 0, -1, TOTAL, 0};
        tbl[1] = '{"cross",     62,     4, 0, -1,     4, 0};
        tbl[2] = '{"toggle",     5,    16, 1, -1,    16, 0};
        tbl[3] = '{"stopped",    8,     8, 2, -1,     8, 0};
        tbl[4] = '{"len0",       5,     0, 0, -1,     0, 0};
        tbl[5] = '{"bad_base", TOTAL,   4, 0, -1,     0, 1};
        tbl[6] = '{"top_word", 103,     1, 1, -1,     1, 0};
        tbl[7] = '{"busy_start", 20,   12, 0,  4,    12, 1};
`ifdef FC_WMEM_WRAP_EN
        tbl[8] = '{"tail",     100,     8, 2, -1,     8, 0};
`else
        tbl[8] = '{"tail",     100,     8, 2, -1,     4, 1};
`endif
        tbl[9] = '{"random",    30,    20, 2, -1,    20, 0};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_load_ready", {63'd0, load_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        check("rst_out_bank", 64'(out_bank), 64'd0);
        rst = 1;

        // full load (value = address), then overwrite 10..12 with a stop pulse
        load_burst(0, TOTAL, 0, 1'b0);
        check("load_err", {63'd0, err}, 64'd0);
        load_burst(10, 3, 16'h2aaa, 1'b1);

        // illegal load base
        @(negedge clk); load_start = 1; load_base = 16'(TOTAL);
        @(negedge clk); load_start = 0;
        check("bad_load_err", {63'd0, err}, 64'd1);
        check("bad_load_busy", {63'd0, busy}, 64'd0);

        foreach (tbl[i]) begin
            do_reset();
            run_burst(tbl[i]);
        end

        // reset in the middle of a read burst
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 40; i++)
            sb.push_back('{data: mem_model[i], bank: 2'(i >= D0), last: (i == 39)});
        delivered = 0;
        @(negedge clk); rd_start = 1; rd_base = 0; rd_len = 16'd40;
        @(negedge clk); rd_start = 0;
        cyc = 0;
        while (delivered < 5 && cyc < 50) begin @(negedge clk); cyc++; end
        check("midrst_reached", 64'(delivered >= 5), 64'd1);
        rst = 0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_out_last", {63'd0, out_last}, 64'd0);
        sb.delete();
        @(negedge clk); rst = 1;
        v = '{"after_rst", 0, 8, 0, -1, 8, 0};
        run_burst(v);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
